// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the ROM/IMEM side.
package imem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream instruction loader: packs little-endian bytes into 32-bit words
// and writes them to consecutive instruction-memory addresses.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = imem_pkg::ADDR_W,
  parameter int DATA_W = imem_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruccion,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  ldr_state_e        state, state_nx;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wcnt;
  logic [ADDR_W:0]   wcnt_inc;
  logic [1:0]        bcnt;
  logic [23:0]       word_q;
  logic              len_ok;
  logic              start_ok;
  logic              accept;
  logic              last_byte;
  logic              words_done;
  logic              we_d;
  logic              done_d;
  logic              err_d;

  assign len_ok     = (length != '0) && (length <= LEN_MAX);
  assign start_ok   = (state == IDLE) && start && len_ok;
  assign accept     = (state == RECV) && byte_valid;
  assign last_byte  = accept && (bcnt == 2'd3);
  assign wcnt_inc   = wcnt + ONE;
  assign words_done = (wcnt_inc == len_q);

  assign byte_ready = (state == RECV);
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok) state_nx = RECV;
      RECV:    if (abort) state_nx = IDLE;
               else if (last_byte) state_nx = WRITE;
      WRITE:   if (abort) state_nx = IDLE;
               else if (words_done) state_nx = DONE;
               else state_nx = RECV;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are computed one cycle early so that we/done/err come straight from flops.
  always_comb begin
    we_d   = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    unique case (state)
      IDLE:    err_d  = start && !len_ok;
      RECV:    we_d   = last_byte && !abort;
      WRITE:   done_d = words_done && !abort;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      len_q       <= '0;
      wcnt        <= '0;
      bcnt        <= '0;
      we          <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      address     <= '0;
      instruccion <= '0;
    end else begin
      we   <= we_d;
      done <= done_d;
      err  <= err_d;
      if (start_ok) begin
        len_q <= length;
        wcnt  <= '0;
        bcnt  <= '0;
      end
      if (accept) bcnt <= bcnt + 2'd1;
      if (we_d) begin
        address     <= wcnt[ADDR_W-1:0];
        instruccion <= {byte_in, word_q};
      end
      if (state == WRITE) wcnt <= wcnt_inc;
    end
  end

  // Partial-word shift register: after three bytes it holds {b2, b1, b0}.
  always_ff @(posedge CLK) begin
    if (accept) word_q <= {byte_in, word_q[23:8]};
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start-validation table, directed corner
// sequences and randomized loads against a word-level reference model.
module tb_imem_loader;

  localparam int AW = 10;

  logic          CLK;
  logic          RST_n;
  logic          start;
  logic [AW:0]   length;
  logic          abort;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] address;
  logic [31:0]   instruccion;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .start      (start),
    .length     (length),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .address    (address),
    .instruccion(instruccion),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;

  logic [7:0]  src[$];
  logic [31:0] written[$];
  logic [31:0] exp_data = '0;
  logic [31:0] exp_addr = '0;

  typedef struct {
    int len;
    bit ab;
    bit exp_err;
    bit exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_addr_hold"}, {22'd0, address}, exp_addr);
    chk({tag, "_instr_hold"}, instruccion, exp_data);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_we"}, {31'd0, we}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 0);
  endtask

  function automatic bit pick_valid(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return c[0];
    return ($urandom_range(0, 3) != 0) || (c % 5 == 4);
  endfunction

  // Word-level model: each word needs four valid cycles in the receive phase,
  // then one write cycle; done follows the last write.
  task automatic run_load(input int L, input int mode, input int dup_at);
    int c;
    int idx;
    c = 0;
    idx = 0;
    written.delete();
    start = 1'b1;
    length = L[AW:0];
    step();
    start = 1'b0;
    for (int w = 0; w < L; w++) begin
      int got;
      logic [31:0] word;
      got = 0;
      word = '0;
      while (got < 4) begin
        bit v;
        v = pick_valid(mode, c);
        byte_valid = v;
        byte_in = v ? src[idx] : 8'($urandom);
        chk("recv_ready", {31'd0, byte_ready}, 1);
        chk("recv_busy", {31'd0, busy}, 1);
        chk("recv_we", {31'd0, we}, 0);
        chk("recv_done", {31'd0, done}, 0);
        chk("recv_err", {31'd0, err}, 0);
        chk_hold("recv");
        if (dup_at == c) begin
          start = 1'b1;
          length = 11'd5;
        end
        step();
        start = 1'b0;
        c++;
        if (v) begin
          word[8*got +: 8] = src[idx];
          idx++;
          got++;
        end
      end
      byte_valid = 1'($urandom);
      byte_in = 8'($urandom);
      exp_addr = w % (1 << AW);
      exp_data = word;
      written.push_back(word);
      chk("wr_we", {31'd0, we}, 1);
      chk("wr_ready", {31'd0, byte_ready}, 0);
      chk("wr_done", {31'd0, done}, 0);
      chk("wr_err", {31'd0, err}, 0);
      chk_hold("wr");
      step();
      c++;
    end
    byte_valid = 1'b0;
    chk("done_pulse", {31'd0, done}, 1);
    chk("done_we", {31'd0, we}, 0);
    chk("done_busy", {31'd0, busy}, 1);
    chk("done_ready", {31'd0, byte_ready}, 0);
    chk_hold("done");
    step();
    chk_quiet("after_done");
    chk_hold("after_done");
  endtask

  task automatic fill_random(input int L);
    src.delete();
    for (int i = 0; i < 4 * L; i++) src.push_back(8'($urandom));
  endtask

  initial begin
    vecs[0] = '{len: 0,    ab: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{len: 1025, ab: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{len: 2047, ab: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{len: 0,    ab: 1'b1, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[4] = '{len: 1,    ab: 1'b1, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[5] = '{len: 1024, ab: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[6] = '{len: 7,    ab: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};

    RST_n = 1'b0;
    start = 1'b0;
    length = '0;
    abort = 1'b0;
    byte_in = '0;
    byte_valid = 1'b0;
    #3;
    chk_quiet("rst");
    chk_hold("rst");
    step();
    step();
    chk_quiet("rst_held");
    RST_n = 1'b1;

    // Two-word load right after reset; start must be taken on the first edge.
    src = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, -1);
    chk("s40_count", written.size(), 2);
    chk("s40_w0", written[0], 32'h0000_0013);
    chk("s40_w1", written[1], 32'h0010_0093);
    chk("s40_last_addr", {22'd0, address}, 1);

    // Start validation table; accepted loads are aborted straight away.
    for (int i = 0; i < 7; i++) begin
      abort = vecs[i].ab;
      start = 1'b1;
      length = vecs[i].len[AW:0];
      step();
      start = 1'b0;
      abort = 1'b0;
      chk($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      chk($sformatf("tbl%0d_we", i), {31'd0, we}, 0);
      if (vecs[i].exp_busy) abort = 1'b1;
      step();
      abort = 1'b0;
      chk_quiet($sformatf("tbl%0d_after", i));
      chk_hold($sformatf("tbl%0d", i));
    end

    // Alternating byte_valid on a single-word load.
    fill_random(1);
    run_load(1, 1, -1);
    chk("s42_count", written.size(), 1);
    chk("s42_word", written[0], {src[3], src[2], src[1], src[0]});

    // Abort two bytes into word 1 of a 3-word load.
    start = 1'b1;
    length = 11'd3;
    step();
    start = 1'b0;
    byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byte_in = 8'hA0 + 8'(i);
      chk("s43_ready", {31'd0, byte_ready}, 1);
      step();
    end
    chk("s43_we0", {31'd0, we}, 1);
    chk("s43_addr0", {22'd0, address}, 0);
    chk("s43_data0", instruccion, 32'hA3A2_A1A0);
    exp_addr = 0;
    exp_data = 32'hA3A2_A1A0;
    step();
    for (int i = 0; i < 2; i++) begin
      byte_in = 8'hB0 + 8'(i);
      step();
    end
    abort = 1'b1;
    byte_in = 8'hB2;
    step();
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      byte_in = 8'hC0 + 8'(i);
      chk_quiet("s43_aborted");
      chk_hold("s43_aborted");
      step();
    end
    byte_valid = 1'b0;
    fill_random(1);
    run_load(1, 0, -1);
    chk("s43_restart_addr", {22'd0, address}, 0);

    // Asynchronous reset in the middle of a receive phase.
    fill_random(2);
    start = 1'b1;
    length = 11'd2;
    step();
    start = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    step();
    #2;
    RST_n = 1'b0;
    #1;
    exp_addr = 0;
    exp_data = 0;
    chk_quiet("s44_async");
    chk_hold("s44_async");
    byte_valid = 1'b0;
    step();
    chk_quiet("s44_held");
    RST_n = 1'b1;
    step();
    chk_quiet("s44_released");

    // Randomized loads with random byte_valid gaps.
    for (int t = 0; t < 8; t++) begin
      int L;
      L = $urandom_range(1, 6);
      fill_random(L);
      run_load(L, 2, -1);
      chk($sformatf("rnd%0d_count", t), written.size(), L);
    end

    // Full-depth load with a stray start while busy.
    src.delete();
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] wv;
      wv = 32'h5A00_0000 + 32'(i);
      for (int k = 0; k < 4; k++) src.push_back(wv[8*k +: 8]);
    end
    run_load(1024, 0, 37);
    chk("s45_count", written.size(), 1024);
    chk("s45_last_addr", {22'd0, address}, 1023);
    chk("s45_last_data", instruccion, 32'h5A00_03FF);
    chk("s45_first_data", written[0], 32'h5A00_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width; must equal 32.
REQ-003 SHALL have port CLK, input, 1, single rising-edge clock.
REQ-004 SHALL have port RST_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a load.
REQ-006 SHALL have port length, input, ADDR_W+1, number of words to load, sampled on start.
REQ-007 SHALL have port abort, input, 1, cancels an active load.
REQ-008 SHALL have port byte_in, input, 8, incoming program byte.
REQ-009 SHALL have port byte_valid, input, 1, byte_in is valid.
REQ-010 SHALL have port byte_ready, output, 1, loader accepts a byte this cycle.
REQ-011 SHALL have port we, output, 1, instruction-memory write strobe.
REQ-012 SHALL have port address, output, ADDR_W, instruction-memory word address.
REQ-013 SHALL have port instruccion, output, DATA_W, instruction word to write.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when a load completes.
REQ-016 SHALL have port err, output, 1, one-cycle pulse when start is rejected.

Function
REQ-017 SHALL implement FSM states IDLE, RECV, WRITE and DONE.
REQ-018 In IDLE, start with 1 <= length <= 2**ADDR_W SHALL latch length, clear the word and byte counters, and enter RECV next cycle.
REQ-019 In IDLE, start with length = 0 or length > 2**ADDR_W SHALL pulse err the next cycle and remain in IDLE.
REQ-020 byte_ready SHALL be 1 only in RECV; a byte is accepted only when byte_valid && byte_ready.
REQ-021 Accepted bytes SHALL pack little-endian: byte k (0..3) of a word goes to instruccion bits [8k+7:8k].
REQ-022 Acceptance of byte 3 SHALL move the FSM to WRITE on the next edge.
REQ-023 WRITE SHALL last exactly one cycle with we=1, address = word counter, and instruccion = assembled word.
REQ-024 After WRITE, the word counter SHALL increment; the FSM goes to DONE if the counter equals length, else back to RECV.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 Latency: we SHALL assert the cycle after the 4th byte is accepted, and done the cycle after the last we.
REQ-027 The word counter SHALL be ADDR_W+1 bits so length = 2**ADDR_W completes without wrap; address uses its low ADDR_W bits (last address 1023).
REQ-028 start SHALL be ignored while busy; err is not pulsed in that case.
REQ-029 abort in RECV or WRITE SHALL return to IDLE next cycle, discard any partial word, suppress we in that cycle, and produce no done.
REQ-030 abort and start in the same cycle in IDLE: start SHALL take effect.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 we, done and err SHALL be registered outputs and never assert together.
REQ-033 address and instruccion SHALL hold their last value outside WRITE.

Reset
REQ-034 RST_n low SHALL asynchronously force state IDLE and clear all counters.
REQ-035 During reset, byte_ready, we, busy, done, err, address and instruccion SHALL all be 0.
REQ-036 Reset mid-load SHALL discard the load with no done; memory already written is left as-is.
REQ-037 After RST_n deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-038 Package imem_pkg SHALL hold ADDR_W, DATA_W and the loader state enum, shared with the ROM/instruction-memory side.
REQ-039 The block SHALL be a single module; the byte packer and counters stay inline, with no sub-module.

Verification
REQ-040 Scenario: start with length=2, bytes 13 00 00 00 93 00 10 00 with byte_valid held high -> we at address 0 with 00000013, then address 1 with 00100093; done one cycle after the second we.
REQ-041 Scenario: start with length=0, and separately length=1025 -> err pulse, no we, busy stays 0.
REQ-042 Scenario: byte_valid toggled every other cycle on a 1-word load -> exactly 4 bytes consumed, single correct we.
REQ-043 Scenario: abort after 2 bytes of word 1 on a length=3 load -> no second we, no done; a new start then writes from address 0.
REQ-044 Scenario: RST_n low during RECV -> all outputs 0 immediately (asynchronous), FSM in IDLE.
REQ-045 Scenario: length=1024 with incrementing words -> last we at address 1023 with no wrap, done asserted, and a second start pulsed while busy is ignored.
